// File: rtl/shared_op_arbiter_pkg.sv
// Shared definitions for the shared-operator arbiter: FSM state encoding and op codes.
package shared_op_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    DELIVER = 2'd2
  } state_e;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd2;
  localparam logic [1:0] OP_PASS = 2'd3;

endpackage

// File: rtl/shared_op_arbiter_if.sv
// Client-side bus of the shared-operator arbiter; master = clients, slave = arbiter.
interface shared_op_arbiter_if #(
  parameter int N_CLIENTS  = 4,
  parameter int DATA_WIDTH = 32
);
  // Handshake: a client raises op_req/res_req and holds it; the arbiter answers with a
  // single-cycle op_ack/res_ack pulse on the edge where operands are captured / res_data is valid.
  logic [N_CLIENTS-1:0]            op_req;
  logic [N_CLIENTS-1:0]            op_ack;
  logic [2*N_CLIENTS-1:0]          op_code;
  logic [DATA_WIDTH*N_CLIENTS-1:0] op_a;
  logic [DATA_WIDTH*N_CLIENTS-1:0] op_b;
  logic [N_CLIENTS-1:0]            res_req;
  logic [N_CLIENTS-1:0]            res_ack;
  logic [DATA_WIDTH-1:0]           res_data;
  logic                            busy;

  modport master (
    output op_req, op_code, op_a, op_b, res_req,
    input  op_ack, res_ack, res_data, busy
  );

  modport slave (
    input  op_req, op_code, op_a, op_b, res_req,
    output op_ack, res_ack, res_data, busy
  );
endinterface

// File: rtl/shared_op_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] index
);

  always_comb begin : pick_search
    logic [IW:0] cand;
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!valid && req[cand[IW-1:0]]) begin
        valid = 1'b1;
        index = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/shared_op_arbiter.sv
// Round-robin arbiter time-sharing one add/sub/mul/pass operator among N_CLIENTS requesters.
// Optional SHARED_OP_ARBITER_STATS_EN adds per-client grant counters and a result-stall counter.
module shared_op_arbiter
  import shared_op_pkg::*;
#(
  parameter int N_CLIENTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  shared_op_arbiter_if.slave    bus,
  output state_e                dbg_state
`ifdef SHARED_OP_ARBITER_STATS_EN
  , output logic [32*N_CLIENTS-1:0] grant_count
  , output logic [31:0]             stall_cycles
`endif
);

  localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e                 state;
  logic [IW-1:0]          ptr;
  logic [IW-1:0]          g;
  logic [IW-1:0]          ptr_next;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;
  logic [CW-1:0]          cnt;
  logic [1:0]             code_q;
  logic [DATA_WIDTH-1:0]  a_q;
  logic [DATA_WIDTH-1:0]  b_q;
  logic [DATA_WIDTH-1:0]  alu_res;
  logic [DATA_WIDTH-1:0]  result_q;
  logic [DATA_WIDTH-1:0]  res_data_q;
  logic [N_CLIENTS-1:0]   op_ack_q;
  logic [N_CLIENTS-1:0]   res_ack_q;

  rr_pick #(.N(N_CLIENTS), .IW(IW)) u_pick (
    .req   (bus.op_req),
    .ptr   (ptr),
    .valid (pick_valid),
    .index (pick_idx)
  );

  // All arithmetic wraps modulo 2^DATA_WIDTH; mul keeps only the low half of the product.
  always_comb begin
    alu_res = a_q;
    case (code_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_MUL:  alu_res = a_q * b_q;
      default: alu_res = a_q;
    endcase
  end

  assign ptr_next = (g == IW'(N_CLIENTS - 1)) ? '0 : g + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      g          <= '0;
      cnt        <= '0;
      code_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      res_data_q <= '0;
      op_ack_q   <= '0;
      res_ack_q  <= '0;
    end else begin
      op_ack_q  <= '0;
      res_ack_q <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            op_ack_q[pick_idx] <= 1'b1;
            code_q             <= bus.op_code[2*pick_idx +: 2];
            a_q                <= bus.op_a[DATA_WIDTH*pick_idx +: DATA_WIDTH];
            b_q                <= bus.op_b[DATA_WIDTH*pick_idx +: DATA_WIDTH];
            g                  <= pick_idx;
            cnt                <= CW'(LATENCY - 1);
            state              <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            result_q <= alu_res;
            state    <= DELIVER;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DELIVER: begin
          // Only the granted client can release the operator; everyone else waits.
          if (bus.res_req[g]) begin
            res_ack_q[g] <= 1'b1;
            res_data_q   <= result_q;
            ptr          <= ptr_next;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.op_ack   = op_ack_q;
  assign bus.res_ack  = res_ack_q;
  assign bus.res_data = res_data_q;
  assign bus.busy     = (state != IDLE);
  assign dbg_state    = state;

`ifdef SHARED_OP_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_count  <= '0;
      stall_cycles <= '0;
    end else begin
      if (state == IDLE && pick_valid)
        grant_count[32*pick_idx +: 32] <= grant_count[32*pick_idx +: 32] + 32'd1;
      if (state == DELIVER && !bus.res_req[g])
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shared_op_arbiter.sv
// Self-checking bench for shared_op_arbiter: vector table, scoreboard queues, corner sequences.
module tb_shared_op_arbiter;
  import shared_op_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int W  = 2 + DW;

  logic   clk;
  logic   rst;
  state_e dbg_state;
  int     cyc;
  int     compared;
  int     mismatched;

  logic [W-1:0] exp_q[$];
  logic [1:0]   gnt_q[$];

  shared_op_arbiter_if #(.N_CLIENTS(N), .DATA_WIDTH(DW)) bus ();

`ifdef SHARED_OP_ARBITER_STATS_EN
  logic [32*N-1:0] grant_count;
  logic [31:0]     stall_cycles;
`endif

  shared_op_arbiter #(.N_CLIENTS(N), .DATA_WIDTH(DW), .LATENCY(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef SHARED_OP_ARBITER_STATS_EN
    , .grant_count  (grant_count)
    , .stall_cycles (stall_cycles)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] onehot_idx(input logic [N-1:0] v);
    logic [1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = 2'(i);
    return r;
  endfunction

  function automatic logic [31:0] ref_op(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (code)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return p[31:0];
      default: return a;
    endcase
  endfunction

  // scoreboard: grants and results are popped in the order the DUT produces them
  always @(negedge clk) begin
    if (|bus.op_ack) begin
      check("op_ack_onehot", 64'($onehot(bus.op_ack)), 64'd1);
      if (gnt_q.size() == 0) check("op_ack_unexpected", 64'(bus.op_ack), 64'd0);
      else check("grant_index", 64'(onehot_idx(bus.op_ack)), 64'(gnt_q.pop_front()));
    end
    if (|bus.res_ack) begin
      check("res_ack_onehot", 64'($onehot(bus.res_ack)), 64'd1);
      if (exp_q.size() == 0) check("res_ack_unexpected", 64'(bus.res_ack), 64'd0);
      else check("result", 64'({onehot_idx(bus.res_ack), bus.res_data}), 64'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic do_reset();
    rst         = 1'b1;
    bus.op_req  = '0;
    bus.res_req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_operands(input int c, input logic [1:0] code, input logic [31:0] a, input logic [31:0] b);
    bus.op_code[2*c +: 2] = code;
    bus.op_a[32*c +: 32]  = a;
    bus.op_b[32*c +: 32]  = b;
  endtask

  task automatic wait_op_ack(input int c, output int t);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.op_ack[c]) break;
    end
    check("op_ack_seen", 64'(bus.op_ack[c]), 64'd1);
    t = cyc;
  endtask

  task automatic wait_res_ack(input int c, output int t);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.res_ack[c]) break;
    end
    check("res_ack_seen", 64'(bus.res_ack[c]), 64'd1);
    t = cyc;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_op(input int c, input logic [1:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, output int lat);
    int t_ack, t_res;
    set_operands(c, code, a, b);
    gnt_q.push_back(2'(c));
    exp_q.push_back({2'(c), exp});
    bus.op_req[c]  = 1'b1;
    bus.res_req[c] = 1'b1;
    wait_op_ack(c, t_ack);
    bus.op_req[c] = 1'b0;
    wait_res_ack(c, t_res);
    bus.res_req[c] = 1'b0;
    lat = t_res - t_ack;
  endtask

  // all clients request together and keep requesting until n grants have been seen
  task automatic all_clients(input int n);
    int seen;
    for (int i = 0; i < N; i++) set_operands(i, OP_ADD, 32'(100*i + 1), 32'(i));
    for (int k = 0; k < n; k++) begin
      gnt_q.push_back(2'(k % N));
      exp_q.push_back({2'(k % N), 32'(101*(k % N) + 1)});
    end
    seen = 0;
    bus.op_req  = '1;
    bus.res_req = '1;
    for (int t = 0; t < 200 && seen < n; t++) begin
      @(negedge clk);
      if (|bus.op_ack) seen++;
    end
    check("all_clients_grants", 64'(seen), 64'(n));
    bus.op_req = '0;
    wait_drain();
    bus.res_req = '0;
  endtask

  typedef struct {
    int          client;
    logic [1:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int   lat, t_a, t_b;
    bit   flag;
    logic [1:0]  rc;
    logic [31:0] ra, rb;
    cyc = 0; compared = 0; mismatched = 0;
    rst = 1'b1;
    bus.op_req = '0; bus.res_req = '0;
    bus.op_code = '0; bus.op_a = '0; bus.op_b = '0;

    vecs[0] = '{1, OP_SUB,  32'd3,          32'd5,          32'hFFFF_FFFE};
    vecs[1] = '{2, OP_MUL,  32'h0001_0000,  32'h0001_0000,  32'h0000_0000};
    vecs[2] = '{3, OP_MUL,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
    vecs[3] = '{0, OP_ADD,  32'hFFFF_FFFF,  32'd2,          32'h0000_0001};
    vecs[4] = '{1, OP_PASS, 32'hDEAD_BEEF,  32'h1234_5678,  32'hDEAD_BEEF};
    vecs[5] = '{2, OP_MUL,  32'd1234,       32'd5678,       32'd7006652};
    vecs[6] = '{3, OP_SUB,  32'd10,         32'd3,          32'd7};
    vecs[7] = '{0, OP_ADD,  32'd0,          32'd0,          32'd0};

    // reset state
    do_reset();
    check("rst_op_ack",   64'(bus.op_ack),   64'd0);
    check("rst_res_ack",  64'(bus.res_ack),  64'd0);
    check("rst_res_data", 64'(bus.res_data), 64'd0);
    check("rst_busy",     64'(bus.busy),     64'd0);
    check("rst_state",    64'(dbg_state),    64'(IDLE));

    // basic add with latency check: res_ack three cycles after op_ack
    run_op(1, OP_ADD, 32'd5, 32'd7, 32'd12, lat);
    check("add_latency", 64'(lat), 64'd3);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].client, vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].exp, lat);
      check("vec_latency", 64'(lat), 64'd3);
    end

    for (int i = 0; i < 6; i++) begin
      rc = 2'($urandom_range(0, 3));
      ra = $urandom();
      rb = $urandom();
      run_op($urandom_range(0, N - 1), rc, ra, rb, ref_op(rc, ra, rb), lat);
    end

    // round-robin: simultaneous requests from ptr=0
    do_reset();
    all_clients(5);

    // result stall blocks other clients
    do_reset();
    set_operands(2, OP_MUL, 32'd6, 32'd7);
    set_operands(3, OP_ADD, 32'd1, 32'd1);
    gnt_q.push_back(2'd2);
    exp_q.push_back({2'd2, 32'd42});
    bus.op_req[2] = 1'b1;
    wait_op_ack(2, t_a);
    bus.op_req[2]  = 1'b0;
    bus.op_req[3]  = 1'b1;
    bus.res_req[3] = 1'b1;
    gnt_q.push_back(2'd3);
    exp_q.push_back({2'd3, 32'd2});
    for (int n = 0; n < 20 && dbg_state != DELIVER; n++) @(negedge clk);
    check("stall_reach_deliver", 64'(dbg_state), 64'(DELIVER));
    flag = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.op_ack[3] || bus.res_ack[2] || !bus.busy) flag = 1'b1;
    end
    check("stall_no_service", 64'(flag), 64'd0);
    check("stall_res_data_held", 64'(bus.res_data), 64'd0);
`ifdef SHARED_OP_ARBITER_STATS_EN
    check("stall_cycles", 64'(stall_cycles), 64'd10);
`endif
    bus.res_req[2] = 1'b1;
    wait_res_ack(2, t_a);
    bus.res_req[2] = 1'b0;
    wait_op_ack(3, t_b);
    check("grant_after_release", 64'(t_b - t_a), 64'd1);
    bus.op_req[3] = 1'b0;
    wait_drain();
    bus.res_req[3] = 1'b0;

    // reset during EXEC drops the op and restarts the search at client 0
    do_reset();
    run_op(1, OP_ADD, 32'd1, 32'd2, 32'd3, lat);
    set_operands(3, OP_PASS, 32'd9, 32'd0);
    gnt_q.push_back(2'd3);
    bus.op_req[3] = 1'b1;
    wait_op_ack(3, t_a);
    bus.op_req[3] = 1'b0;
    check("mid_rst_in_exec", 64'(dbg_state), 64'(EXEC));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy",  64'(bus.busy),  64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
    bus.res_req[3] = 1'b1;
    flag = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (|bus.res_ack) flag = 1'b1;
    end
    check("mid_rst_no_res_ack", 64'(flag), 64'd0);
    bus.res_req[3] = 1'b0;
    set_operands(1, OP_ADD, 32'd20, 32'd22);
    gnt_q.push_back(2'd1);
    exp_q.push_back({2'd1, 32'd42});
    bus.op_req  = 4'b1010;
    bus.res_req = 4'b1010;
    wait_op_ack(1, t_a);
    bus.op_req = '0;
    wait_drain();
    bus.res_req = '0;

`ifdef SHARED_OP_ARBITER_STATS_EN
    do_reset();
    all_clients(4);
    all_clients(4);
    for (int i = 0; i < N; i++) check("grant_count", 64'(grant_count[32*i +: 32]), 64'd2);
`endif

    repeat (4) @(negedge clk);
    check("grant_queue_empty", 64'(gnt_q.size()), 64'd0);
    check("result_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
